// File: rtl/life_sched.sv
// life_sched: paces generation steps from vsync frames and arbitrates
// cell-store writes between the cursor click and a valid/ready pattern
// loader, so that no write ever overlaps a generation step.
// Optional feature macro: SINGLE_STEP_EN adds the step_req_in frame-step input.
module life_sched #(
    parameter int SPEED_W      = 4,
    parameter int POS_W        = 10,
    parameter int GEN_W        = 16,
    parameter int STEP_TIMEOUT = 1048576
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [SPEED_W-1:0] speed_in,
    input  logic               vsync_in,
    input  logic               click_in,
    input  logic [POS_W-1:0]   cursor_x_in,
    input  logic [POS_W-1:0]   cursor_y_in,
    input  logic               load_valid_in,
    input  logic [POS_W-1:0]   load_x_in,
    input  logic [POS_W-1:0]   load_y_in,
    input  logic               load_alive_in,
    output logic               load_ready_out,
    input  logic               load_active_in,
`ifdef SINGLE_STEP_EN
    input  logic               step_req_in,
`endif
    output logic               step_out,
    input  logic               step_done_in,
    output logic               wr_en_out,
    output logic [POS_W-1:0]   wr_x_out,
    output logic [POS_W-1:0]   wr_y_out,
    output logic               wr_alive_out,
    output logic               busy_out,
    output logic [GEN_W-1:0]   gen_count_out,
    output logic               timeout_err_out
);

    // Step cycle counter must be able to hold STEP_TIMEOUT-1.
    localparam int TW = $clog2(STEP_TIMEOUT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_STEP = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_vsync_prev;
    logic [SPEED_W-1:0] r_frame_cnt;
    logic               r_click_pend;
    logic [POS_W-1:0]   r_click_x;
    logic [POS_W-1:0]   r_click_y;
    logic               r_step_pend;
    logic [TW-1:0]      r_tcnt;
    logic               r_step_out;
    logic               r_wr_en;
    logic [POS_W-1:0]   r_wr_x;
    logic [POS_W-1:0]   r_wr_y;
    logic               r_wr_alive;
    logic [GEN_W-1:0]   r_gen;
    logic               r_tout_err;

    logic               w_tick;
    logic               w_pace_en;
    logic [SPEED_W:0]   w_period;
    logic [SPEED_W:0]   w_cnt_inc;
    logic               w_period_hit;
    logic               w_step_set;
    logic               w_click_go;
    logic               w_load_go;
    logic               w_step_go;
    logic               w_done;
    logic               w_tout;

    // Frame tick is the falling edge of the active-low vsync.
    assign w_tick    = r_vsync_prev & ~vsync_in;
    assign w_pace_en = w_tick & (speed_in != '0) & ~load_active_in;

    // period = 2^SPEED_W - speed; compared against frame_cnt+1 so a speed
    // change lands on the next tick without reloading the counter.
    assign w_period     = {1'b1, {SPEED_W{1'b0}}} - {1'b0, speed_in};
    assign w_cnt_inc    = {1'b0, r_frame_cnt} + (SPEED_W+1)'(1);
    assign w_period_hit = (w_cnt_inc >= w_period);

`ifdef SINGLE_STEP_EN
    assign w_step_set = (w_pace_en & w_period_hit)
                      | (step_req_in & (speed_in == '0) & ~load_active_in);
`else
    assign w_step_set = w_pace_en & w_period_hit;
`endif

    // Frame pacing: remember last vsync level and count frames per step.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_vsync_prev <= 1'b1;
            r_frame_cnt  <= '0;
        end else begin
            r_vsync_prev <= vsync_in;
            if (w_pace_en) begin
                if (w_period_hit) r_frame_cnt <= '0;
                else              r_frame_cnt <= w_cnt_inc[SPEED_W-1:0];
            end
        end
    end

    // Pending requests: a new click or step request wins over a same-cycle
    // consume, so nothing arriving on the grant cycle is lost.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_click_pend <= 1'b0;
            r_click_x    <= '0;
            r_click_y    <= '0;
            r_step_pend  <= 1'b0;
        end else begin
            if (click_in) begin
                r_click_pend <= 1'b1;
                r_click_x    <= cursor_x_in;
                r_click_y    <= cursor_y_in;
            end else if (w_click_go) begin
                r_click_pend <= 1'b0;
            end
            if (w_step_set)     r_step_pend <= 1'b1;
            else if (w_step_go) r_step_pend <= 1'b0;
        end
    end

    // Next-state and grant decode; IDLE priority is click, loader, step.
    always_comb begin
        w_state_nxt = r_state;
        w_click_go  = 1'b0;
        w_load_go   = 1'b0;
        w_step_go   = 1'b0;
        w_done      = 1'b0;
        w_tout      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_click_pend) begin
                    w_click_go = 1'b1;
                end else if (load_valid_in) begin
                    w_load_go = 1'b1;
                end else if (r_step_pend) begin
                    w_step_go   = 1'b1;
                    w_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                if (step_done_in) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_tcnt == TW'(STEP_TIMEOUT - 1)) begin
                    w_tout      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Write port register: one cell per granted cycle, held data otherwise.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_en    <= 1'b0;
            r_wr_x     <= '0;
            r_wr_y     <= '0;
            r_wr_alive <= 1'b0;
        end else begin
            r_wr_en <= w_click_go | w_load_go;
            if (w_click_go) begin
                r_wr_x     <= r_click_x;
                r_wr_y     <= r_click_y;
                r_wr_alive <= 1'b1;
            end else if (w_load_go) begin
                r_wr_x     <= load_x_in;
                r_wr_y     <= load_y_in;
                r_wr_alive <= load_alive_in;
            end
        end
    end

    // Step launch pulse and watchdog cycle count while a step runs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_step_out <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            r_step_out <= w_step_go;
            if (w_step_go)              r_tcnt <= '0;
            else if (r_state == S_STEP) r_tcnt <= r_tcnt + TW'(1);
        end
    end

    // Completed-generation counter and sticky watchdog flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_gen      <= '0;
            r_tout_err <= 1'b0;
        end else begin
            if (w_done) r_gen      <= r_gen + GEN_W'(1);
            if (w_tout) r_tout_err <= 1'b1;
        end
    end

    // Ready is combinational so a loader cell is taken the cycle it is offered.
    assign load_ready_out  = w_load_go & ~rst_in;
    assign step_out        = r_step_out;
    assign busy_out        = (r_state == S_STEP);
    assign wr_en_out       = r_wr_en;
    assign wr_x_out        = r_wr_x;
    assign wr_y_out        = r_wr_y;
    assign wr_alive_out    = r_wr_alive;
    assign gen_count_out   = r_gen;
    assign timeout_err_out = r_tout_err;

endmodule

// File: tb/tb_life_sched.sv
// tb_life_sched: directed scenarios plus randomized traffic, with every
// cycle's outputs compared against a behavioural scheduler model.
module tb_life_sched;
    localparam int SPEED_W = 4;
    localparam int POS_W   = 10;
    localparam int GEN_W   = 16;
    localparam int TO      = 64;

    logic               clk = 1'b0;
    logic               rst_in = 1'b1;
    logic [SPEED_W-1:0] speed_in = '0;
    logic               vsync_in = 1'b1;
    logic               click_in = 1'b0;
    logic [POS_W-1:0]   cursor_x_in = '0, cursor_y_in = '0;
    logic               load_valid_in = 1'b0;
    logic [POS_W-1:0]   load_x_in = '0, load_y_in = '0;
    logic               load_alive_in = 1'b0;
    logic               load_ready_out;
    logic               load_active_in = 1'b0;
    logic               step_req_in = 1'b0;
    logic               step_out;
    logic               step_done_in = 1'b0;
    logic               wr_en_out;
    logic [POS_W-1:0]   wr_x_out, wr_y_out;
    logic               wr_alive_out;
    logic               busy_out;
    logic [GEN_W-1:0]   gen_count_out;
    logic               timeout_err_out;

    always #5 clk = ~clk;

    life_sched #(.SPEED_W(SPEED_W), .POS_W(POS_W), .GEN_W(GEN_W), .STEP_TIMEOUT(TO)) dut (
        .clk_in(clk), .rst_in(rst_in), .speed_in(speed_in), .vsync_in(vsync_in),
        .click_in(click_in), .cursor_x_in(cursor_x_in), .cursor_y_in(cursor_y_in),
        .load_valid_in(load_valid_in), .load_x_in(load_x_in), .load_y_in(load_y_in),
        .load_alive_in(load_alive_in), .load_ready_out(load_ready_out),
        .load_active_in(load_active_in),
`ifdef SINGLE_STEP_EN
        .step_req_in(step_req_in),
`endif
        .step_out(step_out), .step_done_in(step_done_in), .wr_en_out(wr_en_out),
        .wr_x_out(wr_x_out), .wr_y_out(wr_y_out), .wr_alive_out(wr_alive_out),
        .busy_out(busy_out), .gen_count_out(gen_count_out), .timeout_err_out(timeout_err_out)
    );

    int n_chk = 0, n_fail = 0, n_steps = 0;
    bit chk_en = 1'b0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Behavioural model: pending requests as flags, a step as "busy for N cycles".
    bit m_busy, m_clk_pend, m_step_pend, m_err, m_wr, m_stp, m_prev_vs, m_wa;
    int m_fcnt, m_gen, m_cyc, m_cx, m_cy, m_wx, m_wy;

    always @(posedge clk) begin : model
        bit tick, set_step;
        if (rst_in) begin
            m_busy = 0; m_clk_pend = 0; m_step_pend = 0; m_err = 0; m_wr = 0; m_stp = 0;
            m_prev_vs = 1; m_fcnt = 0; m_gen = 0; m_cyc = 0; m_cx = 0; m_cy = 0;
        end else begin
            tick = m_prev_vs && !vsync_in;
            m_prev_vs = vsync_in;
            set_step = 0;
            if (tick && speed_in != 0 && !load_active_in) begin
                if (m_fcnt + 1 >= (1 << SPEED_W) - int'(speed_in)) begin
                    set_step = 1; m_fcnt = 0;
                end else m_fcnt++;
            end
`ifdef SINGLE_STEP_EN
            if (step_req_in && speed_in == 0 && !load_active_in) set_step = 1;
`endif
            m_wr = 0; m_stp = 0;
            if (!m_busy) begin
                if (m_clk_pend) begin
                    m_wr = 1; m_wx = m_cx; m_wy = m_cy; m_wa = 1; m_clk_pend = 0;
                end else if (load_valid_in) begin
                    m_wr = 1; m_wx = int'(load_x_in); m_wy = int'(load_y_in); m_wa = load_alive_in;
                end else if (m_step_pend) begin
                    m_stp = 1; m_step_pend = 0; m_busy = 1; m_cyc = 0;
                end
            end else begin
                m_cyc++;
                if (step_done_in) begin
                    m_gen = (m_gen + 1) % (1 << GEN_W); m_busy = 0;
                end else if (m_cyc == TO) begin
                    m_err = 1; m_busy = 0;
                end
            end
            if (click_in) begin
                m_clk_pend = 1; m_cx = int'(cursor_x_in); m_cy = int'(cursor_y_in);
            end
            if (set_step) m_step_pend = 1;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_en", 32'(wr_en_out), 32'(m_wr));
            if (m_wr) begin
                check("wr_x", 32'(wr_x_out), m_wx);
                check("wr_y", 32'(wr_y_out), m_wy);
                check("wr_alive", 32'(wr_alive_out), 32'(m_wa));
            end
            check("step_out", 32'(step_out), 32'(m_stp));
            check("busy", 32'(busy_out), 32'(m_busy));
            check("gen_count", 32'(gen_count_out), m_gen);
            check("timeout_err", 32'(timeout_err_out), 32'(m_err));
            check("load_ready", 32'(load_ready_out),
                  32'(!rst_in && !m_busy && !m_clk_pend && load_valid_in));
            if (step_out) n_steps++;
        end
    end

    // One cycle of stimulus time; also plays life_logic returning step_done.
    int cd = 0;
    int done_delay = 10;
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            click_in = 0; step_done_in = 0; step_req_in = 0;
            if (cd > 0) begin cd--; if (cd == 0) step_done_in = 1; end
            if (step_out && done_delay > 0) cd = done_delay;
            if (rst_in) cd = 0;
        end
    endtask

    task automatic frame();
        vsync_in = 0; cyc(2);
        vsync_in = 1; cyc(30);
    endtask

    task automatic wait_busy();
        for (int k = 0; k < 60 && !busy_out; k++) cyc(1);
        check("enter_step", 32'(busy_out), 32'd1);
    endtask

    int s0, g0, bc, idx;
    bit acc;
    int ev_v[$], ev_c[$];

    initial begin
        // Reset state, with a loader offering a cell to show ready is gated.
        rst_in = 1; load_valid_in = 1;
        cyc(1); chk_en = 1; cyc(1);
        check("rst_wr_en", 32'(wr_en_out), 0);
        check("rst_step", 32'(step_out), 0);
        check("rst_busy", 32'(busy_out), 0);
        check("rst_gen", 32'(gen_count_out), 0);
        check("rst_err", 32'(timeout_err_out), 0);
        check("rst_ready", 32'(load_ready_out), 0);
        rst_in = 0; load_valid_in = 0; cyc(2);

        // Fastest speed: one step per frame.
        speed_in = 15; done_delay = 10; s0 = n_steps;
        repeat (5) frame();
        check("speed15_steps", n_steps - s0, 5);
        check("speed15_gen", 32'(gen_count_out), 5);

        // Period 4: steps on frames 4, 8, 12; then paused.
        speed_in = 12; s0 = n_steps;
        for (int f = 1; f <= 12; f++) begin
            frame();
            if (f == 3)  check("p4_f3", n_steps - s0, 0);
            if (f == 4)  check("p4_f4", n_steps - s0, 1);
            if (f == 8)  check("p4_f8", n_steps - s0, 2);
        end
        check("p4_f12", n_steps - s0, 3);
        speed_in = 0; s0 = n_steps;
        repeat (10) frame();
        check("paused_steps", n_steps - s0, 0);
        check("paused_gen", 32'(gen_count_out), 8);

        // Click during STEP waits for the step to finish.
        done_delay = -1; speed_in = 15;
        vsync_in = 0; wait_busy(); vsync_in = 1; speed_in = 0;
        cyc(2);
        click_in = 1; cursor_x_in = 3; cursor_y_in = 7;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            check("no_wr_in_step", 32'(wr_en_out), 0);
        end
        step_done_in = 1;
        cyc(1);
        check("idle_after_done", 32'(busy_out), 0);
        check("wr_not_yet", 32'(wr_en_out), 0);
        cyc(1);
        check("click_wr_en", 32'(wr_en_out), 1);
        check("click_wr_x", 32'(wr_x_out), 3);
        check("click_wr_y", 32'(wr_y_out), 7);
        check("click_wr_alive", 32'(wr_alive_out), 1);
        cyc(3);

        // Click + step pending together with a 4-cell loader burst.
        speed_in = 15; vsync_in = 0; wait_busy(); vsync_in = 1;
        cyc(3);
        click_in = 1; cursor_x_in = 9; cursor_y_in = 9;
        cyc(1); vsync_in = 0; cyc(2); vsync_in = 1; cyc(2); speed_in = 0;
        idx = 0; acc = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (wr_en_out) begin ev_v.push_back(int'(wr_x_out)); ev_c.push_back(i); end
            if (step_out)  begin ev_v.push_back(99); ev_c.push_back(i); end
            step_done_in = (i == 0);
            if (acc) idx++;
            load_valid_in = (idx < 4);
            load_x_in = POS_W'(idx + 1); load_y_in = POS_W'(idx + 1); load_alive_in = idx[0];
            #1 acc = load_ready_out && load_valid_in;
        end
        load_valid_in = 0;
        check("burst_events", ev_v.size(), 6);
        if (ev_v.size() == 6) begin
            check("burst_click_first", ev_v[0], 9);
            check("burst_cell1", ev_v[1], 1);
            check("burst_cell4", ev_v[4], 4);
            check("burst_step_last", ev_v[5], 99);
            check("burst_consecutive", ev_c[5] - ev_c[0], 5);
        end
        cyc(1); step_done_in = 1; cyc(3);

        // Loader session suppresses pacing; loader keeps being served.
        done_delay = 10; speed_in = 15; load_active_in = 1; s0 = n_steps;
        load_valid_in = 1; load_x_in = 5; load_y_in = 6; load_alive_in = 1;
        repeat (20) frame();
        check("active_no_steps", n_steps - s0, 0);
        check("active_ready", 32'(load_ready_out), 1);
        load_valid_in = 0; load_active_in = 0; cyc(2);

        // Watchdog: withhold step_done.
        done_delay = -1; g0 = int'(gen_count_out);
        vsync_in = 0; wait_busy(); vsync_in = 1; speed_in = 0;
        bc = 0;
        for (int k = 0; k < 200 && busy_out; k++) begin bc++; cyc(1); end
        check("timeout_cycles", bc, TO);
        check("timeout_flag", 32'(timeout_err_out), 1);
        check("timeout_gen", 32'(gen_count_out), g0);
        cyc(3);
        rst_in = 1; cyc(2); rst_in = 0;
        check("rst_clears_err", 32'(timeout_err_out), 0);
        check("rst_clears_gen", 32'(gen_count_out), 0);
        cyc(2);

        // Randomized traffic against the model.
        done_delay = 10;
        for (int i = 0; i < 4000; i++) begin
            cyc(1);
            if ($urandom_range(7) == 0) vsync_in = ~vsync_in;
            if ($urandom_range(199) == 0) speed_in = SPEED_W'($urandom_range(15));
            if ($urandom_range(29) == 0) begin
                click_in = 1; cursor_x_in = POS_W'($urandom); cursor_y_in = POS_W'($urandom);
            end
            load_valid_in = ($urandom_range(2) == 0);
            load_x_in = POS_W'($urandom); load_y_in = POS_W'($urandom);
            load_alive_in = $urandom_range(1) == 1;
            if ($urandom_range(99) == 0) load_active_in = ~load_active_in;
            if ($urandom_range(49) == 0)
                done_delay = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(30, 1));
            if ($urandom_range(63) == 0) step_done_in = 1;
            if ($urandom_range(31) == 0) step_req_in = 1;
            rst_in = ($urandom_range(499) == 0);
        end
        rst_in = 0; cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
